// File: rtl/matmul_result_writer_if.sv
// rtl/matmul_result_writer_if.sv - result SRAM write port (valid/ready)
interface matmul_result_writer_if #(
  parameter int DW = 21,
  parameter int AW = 10
);
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic          mem_ready;

  modport master (output mem_we, mem_addr, mem_di, input mem_ready);
  modport slave  (input mem_we, mem_addr, mem_di, output mem_ready);
endinterface

// File: rtl/matmul_result_writer.sv
// rtl/matmul_result_writer.sv - buffers matmul C results and writes them to the result SRAM
module matmul_result_writer #(
  parameter int DW    = 21,
  parameter int AW    = 10,
  parameter int DEPTH = 4,
  parameter int NRES  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   res_valid,
  input  logic [DW-1:0]          res_data,
  input  logic [AW-1:0]          res_addr,
  input  logic                   ctrl_done,
  matmul_result_writer_if.master mem,
  output logic [AW:0]            wr_count,
  output logic [DW+AW-1:0]       checksum,
  output logic                   busy,
  output logic                   wr_done,
  output logic                   ovf,
  output logic                   cnt_err
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;

  logic          push_en, push_ok, pop, full, drop;
  logic [AW:0]   wr_count_next;
  logic [DW+AW-1:0] checksum_next;

  assign busy    = (state == RUN) || (state == DRAIN);
  assign wr_done = (state == DONE);

  // Head outputs are forced to zero while empty so reset leaves the port quiet.
  assign mem.mem_we   = (count != '0);
  assign mem.mem_addr = mem.mem_we ? addr_q[rd_ptr] : '0;
  assign mem.mem_di   = mem.mem_we ? data_q[rd_ptr] : '0;

  assign full    = (count == (PW+1)'(DEPTH));
  assign pop     = mem.mem_we && mem.mem_ready;
  assign push_en = res_valid && busy;
  assign push_ok = push_en && (!full || pop);
  assign drop    = push_en && full && !pop;

  always_comb begin
    count_next = count;
    if (push_ok && !pop)
      count_next = count + (PW+1)'(1);
    else if (!push_ok && pop)
      count_next = count - (PW+1)'(1);
  end

  always_comb begin
    wr_count_next = wr_count;
    checksum_next = checksum;
    if (pop) begin
      if (wr_count != '1)
        wr_count_next = wr_count + (AW+1)'(1);
      checksum_next = checksum + {{AW{1'b0}}, mem.mem_di};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_count <= '0;
      checksum <= '0;
      ovf      <= 1'b0;
      cnt_err  <= 1'b0;
    end else begin
      if (push_ok) begin
        addr_q[wr_ptr] <= res_addr;
        data_q[wr_ptr] <= res_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      wr_count <= wr_count_next;
      checksum <= checksum_next;
      if (drop)
        ovf <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            wr_count <= '0;
            checksum <= '0;
            ovf      <= 1'b0;
            cnt_err  <= 1'b0;
          end
        end
        RUN: begin
          if (ctrl_done)
            state <= DRAIN;
        end
        DRAIN: begin
          // The final write of the drain counts toward the completeness check.
          if (count_next == '0 && !push_ok) begin
            state   <= DONE;
            cnt_err <= (wr_count_next != (AW+1)'(NRES));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_result_writer.sv
// tb/tb_matmul_result_writer.sv - directed self-checking bench for matmul_result_writer
module tb_matmul_result_writer;
  localparam int DW = 21;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_addr;
  logic          ctrl_done;
  logic [AW:0]   wr_count;
  logic [DW+AW-1:0] checksum;
  logic          busy, wr_done, ovf, cnt_err;

  int errors = 0;
  int checks = 0;

  matmul_result_writer_if #(.DW(DW), .AW(AW)) mif ();

  matmul_result_writer #(.DW(DW), .AW(AW), .DEPTH(4), .NRES(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_addr  (res_addr),
    .ctrl_done (ctrl_done),
    .mem       (mif),
    .wr_count  (wr_count),
    .checksum  (checksum),
    .busy      (busy),
    .wr_done   (wr_done),
    .ovf       (ovf),
    .cnt_err   (cnt_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    res_valid = 1'b1;
    res_addr  = AW'(a);
    res_data  = DW'(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; res_valid = 1'b0; res_data = '0; res_addr = '0;
    ctrl_done = 1'b0; mif.mem_ready = 1'b0;

    // Reset and idle behaviour
    repeat (3) tick();
    rst = 1'b0;
    push(0, 1);
    tick();
    chk("rst_mem_we", mif.mem_we, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_mem_di", mif.mem_di, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt_err", cnt_err, 0);
    tick();
    chk("idle_no_push", mif.mem_we, 0);
    res_valid = 1'b0;

    // Basic flow
    mif.mem_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("basic_busy", busy, 1);
    push(0, 5); tick();
    chk("basic_we0", mif.mem_we, 1);
    chk("basic_addr0", mif.mem_addr, 0);
    chk("basic_di0", mif.mem_di, 5);
    push(1, 7); ctrl_done = 1'b1; tick();
    res_valid = 1'b0; ctrl_done = 1'b0;
    chk("basic_addr1", mif.mem_addr, 1);
    chk("basic_di1", mif.mem_di, 7);
    chk("basic_cnt1", wr_count, 1);
    tick();
    chk("basic_wr_count", wr_count, 2);
    chk("basic_checksum", checksum, 12);
    chk("basic_wr_done", wr_done, 1);
    chk("basic_cnt_err", cnt_err, 1);
    chk("basic_we_off", mif.mem_we, 0);

    // Restart from DONE, then backpressure
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_wr_count", wr_count, 0);
    chk("restart_checksum", checksum, 0);
    chk("restart_cnt_err", cnt_err, 0);
    chk("restart_busy", busy, 1);
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(10 + i, 100 + i); tick();
    end
    res_valid = 1'b0;
    chk("bp_we", mif.mem_we, 1);
    chk("bp_head_addr", mif.mem_addr, 10);
    chk("bp_head_di", mif.mem_di, 100);
    chk("bp_ovf0", ovf, 0);
    mif.mem_ready = 1'b1; push(14, 104); tick();
    chk("bp_accept_ovf", ovf, 0);
    chk("bp_accept_head", mif.mem_addr, 11);
    mif.mem_ready = 1'b0; push(15, 105); tick();
    res_valid = 1'b0;
    chk("bp_drop_ovf", ovf, 1);
    chk("bp_drop_head", mif.mem_addr, 11);
    ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
    mif.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_we", mif.mem_we, 1);
      chk("bp_drain_addr", mif.mem_addr, 64'(11 + k));
      chk("bp_drain_di", mif.mem_di, 64'(101 + k));
      tick();
    end
    chk("bp_wr_done", wr_done, 1);
    chk("bp_wr_count", wr_count, 5);
    chk("bp_checksum", checksum, 510);
    chk("bp_ovf_sticky", ovf, 1);

    // Full 1024-result product with toggling ready
    start = 1'b1; tick(); start = 1'b0;
    chk("full_ovf_clr", ovf, 0);
    for (int i = 0; i < 1024; i++) begin
      push(i, i); mif.mem_ready = 1'b1; tick();
      res_valid = 1'b0; mif.mem_ready = 1'b0; tick();
    end
    ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
    mif.mem_ready = 1'b1;
    for (int c = 0; c < 20 && !wr_done; c++) tick();
    chk("full_wr_done", wr_done, 1);
    chk("full_wr_count", wr_count, 1024);
    chk("full_checksum", checksum, 523776);
    chk("full_cnt_err", cnt_err, 0);
    chk("full_ovf", ovf, 0);
    chk("full_we_off", mif.mem_we, 0);

    // Done while results are still queued
    start = 1'b1; tick(); start = 1'b0;
    mif.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(20 + i, 30 + i); tick();
    end
    push(23, 33); ctrl_done = 1'b1; tick();
    res_valid = 1'b0; ctrl_done = 1'b0;
    repeat (5) tick();
    chk("pend_we", mif.mem_we, 1);
    chk("pend_head", mif.mem_addr, 20);
    chk("pend_busy", busy, 1);
    mif.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("pend_addr", mif.mem_addr, 64'(20 + k));
      chk("pend_di", mif.mem_di, 64'(30 + k));
      chk("pend_not_done", wr_done, 0);
      tick();
    end
    chk("pend_wr_done", wr_done, 1);
    chk("pend_wr_count", wr_count, 4);
    chk("pend_checksum", checksum, 126);

    // Reset during DRAIN with two entries queued
    start = 1'b1; tick(); start = 1'b0;
    chk("mid_restart_cnt", wr_count, 0);
    mif.mem_ready = 1'b1;
    push(40, 50); tick();
    push(41, 51); tick();
    mif.mem_ready = 1'b0;
    push(42, 52); tick();
    res_valid = 1'b0; ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_head", mif.mem_addr, 41);
    chk("mid_wr_count", wr_count, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_we", mif.mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", wr_done, 0);
    chk("mid_rst_wr_count", wr_count, 0);
    chk("mid_rst_checksum", checksum, 0);
    chk("mid_rst_addr", mif.mem_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matmul_result_writer.md
Name: matmul_result_writer

Overview:
- Downstream stage of the 32x32 matrix-multiply controller. Consumes the stream of 21-bit C elements (mul_out) and their C addresses (counter_C).
- Buffers results in a small FIFO and writes them to the result SRAM over a valid/ready write port.
- Tracks the write count and a running checksum. Raises wr_done once the controller has signalled done and every buffered result has been written.

Parameters:
- DW, 21, result data width (matches mul_out)
- AW, 10, result address width (1024 C elements)
- DEPTH, 4, FIFO entries (power of two, >=2)
- NRES, 1024, expected results per matrix product

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  pulse; arms the block for a new product
- res_valid  input  1  result strobe from controller, one result per high cycle
- res_data  input  DW  result value (mul_out)
- res_addr  input  AW  result address (counter_C)
- ctrl_done  input  1  controller done pulse
- mem_ready  input  1  SRAM write port accepts this cycle
- mem_we  output  1  write request valid
- mem_addr  output  AW  write address (FIFO head)
- mem_di  output  DW  write data (FIFO head)
- wr_count  output  AW+1  results written since start
- checksum  output  DW+AW  running sum of written data, unsigned, wraps mod 2^(DW+AW)
- busy  output  1  high in RUN or DRAIN
- wr_done  output  1  high in DONE
- ovf  output  1  sticky: a result was dropped because the FIFO was full
- cnt_err  output  1  sticky: DONE entered with wr_count != NRES

Behaviour:
- Reset values: FIFO empty, state IDLE, all outputs 0 (mem_we, mem_addr, mem_di, wr_count, checksum, busy, wr_done, ovf, cnt_err).
- Reset asserted mid-operation discards FIFO contents and returns to IDLE next cycle.
- States:
  - IDLE: on start -> RUN. Clear wr_count, checksum, ovf, cnt_err.
  - RUN: on ctrl_done -> DRAIN.
  - DRAIN: when FIFO becomes empty (count 0 after this cycle's pop, no push) -> DONE.
  - DONE: wr_done=1. On start -> RUN, clearing the same fields as the IDLE->RUN transition.
  - start in RUN or DRAIN is ignored.
- Push:
  - Occurs when res_valid=1 in RUN, or in DRAIN (including the same cycle ctrl_done is sampled in RUN).
  - res_valid in IDLE or DONE is ignored (no push, no flag).
  - Push is accepted if FIFO not full, or if full and a pop occurs the same cycle.
  - Otherwise the result is dropped and ovf is set.
- Pop/handshake:
  - mem_we = FIFO non-empty. mem_addr/mem_di = head entry, driven from registered storage.
  - A write completes on a cycle with mem_we=1 and mem_ready=1. The head advances at that clock edge.
  - mem_addr/mem_di hold stable while mem_we=1 and mem_ready=0.
- Latency: a result pushed at edge N appears on mem_we/mem_addr/mem_di after edge N (cycle N+1) if the FIFO was empty.
- Simultaneous push and pop keeps occupancy unchanged. Pointers wrap modulo DEPTH.
- On each completed write, increment wr_count (saturating at 2^(AW+1)-1) and add mem_di to checksum (zero-extended).
- On the DRAIN->DONE transition, set cnt_err if wr_count (including the final write) != NRES.
- ctrl_done in IDLE or DONE is ignored.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release with res_valid=1, data 0x1 -> all outputs 0, mem_we stays 0, state IDLE.
- Basic flow: start; push (addr 0, data 5), (addr 1, data 7) with mem_ready=1; ctrl_done -> writes addr 0/data 5 then addr 1/data 7 on consecutive cycles starting one cycle after the first push. wr_count=2, checksum=12. wr_done=1, cnt_err=1 (NRES=1024).
- Backpressure: mem_ready=0, push 4 results -> FIFO full, mem_we=1, head held at the first entry. 5th push with no pop -> ovf=1, dropped. 5th push issued in a cycle with mem_ready=1 instead -> accepted, ovf=0.
- Full run: 1024 results with addr 0..1023, data = addr, mem_ready toggling 1/0 -> wr_count=1024, checksum=523776, cnt_err=0, wr_done=1 once the FIFO drains.
- Done with pending data: ctrl_done in the same cycle as a push while 3 entries are queued and mem_ready=0 for 5 cycles -> all 4 entries written after mem_ready rises, in order; wr_done asserts the cycle after the last write.
- Restart and mid-op reset: start in DONE clears counters and returns to RUN. rst asserted in DRAIN with 2 entries queued -> next cycle mem_we=0, state IDLE, wr_count=0.
